// File: rtl/mon_pkg.sv
// mon_pkg: shared definitions for the monitor-link transmit path.
//   - Opcode bytes that form the top byte of every outbound packet.
//   - packet_t: the 40-bit packet presented to the Sender (bit 39 = MSB).
//   - state_t:  scheduler FSM states.
//   - src_t:    which pending source owns the packet currently being issued.
//   - make_packet(): builds {opcode, payload, 16'h0000}.
package mon_pkg;

    localparam logic [7:0] OP_POWER_ON = 8'hC0;
    localparam logic [7:0] OP_SND_REQ  = 8'h07;
    localparam logic [7:0] OP_KBD      = 8'hC5;
    localparam logic [7:0] OP_MOUSE    = 8'hC6;

    // One keyboard/mouse queue entry is {is_mouse, data[15:0]}.
    localparam int KB_ENTRY_W = 17;

    typedef logic [39:0] packet_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP
    } state_t;

    typedef enum logic [1:0] {
        SRC_PO,
        SRC_SND,
        SRC_KB
    } src_t;

    function automatic packet_t make_packet(input logic [7:0] op, input logic [15:0] payload);
        return {op, payload, 16'h0000};
    endfunction

endpackage

// File: rtl/mon_tx_fifo.sv
// mon_tx_fifo: synchronous FIFO, DEPTH entries of WIDTH bits.
//   clk, reset : clock, synchronous active-high reset (clears pointers only)
//   push, wdata: write request and data; accepted when not full, or when a
//                pop happens in the same cycle (full + push + pop is legal)
//   pop        : read request; ignored when empty
//   rdata      : head entry (valid while empty = 0)
//   full, empty: occupancy flags
// DEPTH must be a power of two >= 2.
module mon_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and an unreset array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mon_tx_scheduler.sv
// mon_tx_scheduler: arbitrates power-on, sample-request and keyboard/mouse
// packets onto the Sender's single 40-bit port and enforces an idle gap of
// GAP_CYCLES mon_clk cycles after every accepted packet.
//   mon_clk       : link clock
//   reset         : synchronous active-high reset
//   power_on_req  : pulse, request a power-on packet (coalesced while pending)
//   kb_valid      : pulse, a keyboard/mouse event {kb_is_mouse, kb_data}
//   snd_req_mode  : sample-request mode; low cancels a pending sample request
//   snd_req_tick  : pulse, request one sample-request packet (mode must be 1)
//   out_data      : registered packet, changes only on IDLE -> ISSUE
//   out_valid     : registered, high from IDLE -> ISSUE until acceptance
//   out_ready     : Sender accepts the packet this cycle
//   kb_overflow   : registered pulse, a keyboard event was dropped (queue full)
//   drop_count    : only with MON_TX_DROP_COUNT_EN; saturating count of
//                   kb_overflow pulses
// Priority in IDLE: power-on > sample request > keyboard queue.
module mon_tx_scheduler
    import mon_pkg::*;
#(
    parameter int KB_DEPTH   = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic        mon_clk,
    input  logic        reset,
    input  logic        power_on_req,
    input  logic        kb_valid,
    input  logic        kb_is_mouse,
    input  logic [15:0] kb_data,
    input  logic        snd_req_mode,
    input  logic        snd_req_tick,
    output logic [39:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        kb_overflow
`ifdef MON_TX_DROP_COUNT_EN
    ,
    output logic [7:0]  drop_count
`endif
);

    localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    state_t                 state;
    src_t                   owner;
    logic [CNT_W-1:0]       gap_cnt;
    logic                   po_pend;
    logic                   snd_pend;
    logic                   snd_active;
    logic                   accept;

    logic [KB_ENTRY_W-1:0]  kb_rdata;
    logic                   kb_full;
    logic                   kb_empty;
    logic                   kb_pop;
    logic                   kb_drop;

    packet_t                win_pkt;
    src_t                   win_src;
    logic                   any_pend;

    // A pending sample request only counts while the mode is still high, so a
    // falling mode cancels it in the very cycle it is seen low.
    assign snd_active = snd_pend && snd_req_mode;
    assign any_pend   = po_pend || snd_active || !kb_empty;
    assign accept     = (state == ISSUE) && out_ready;

    // The queue entry moves into the out_data register when it wins, freeing
    // its slot immediately; the issuing packet is owned by the output register.
    assign kb_pop  = (state == IDLE) && !po_pend && !snd_active && !kb_empty;
    assign kb_drop = kb_valid && kb_full && !kb_pop;

    mon_tx_fifo #(
        .DEPTH (KB_DEPTH),
        .WIDTH (KB_ENTRY_W)
    ) u_kb_fifo (
        .clk   (mon_clk),
        .reset (reset),
        .push  (kb_valid),
        .wdata ({kb_is_mouse, kb_data}),
        .pop   (kb_pop),
        .rdata (kb_rdata),
        .full  (kb_full),
        .empty (kb_empty)
    );

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        win_src = SRC_KB;
        win_pkt = make_packet(kb_rdata[16] ? OP_MOUSE : OP_KBD, kb_rdata[15:0]);
        if (po_pend) begin
            win_src = SRC_PO;
            win_pkt = make_packet(OP_POWER_ON, 16'h0000);
        end else if (snd_active) begin
            win_src = SRC_SND;
            win_pkt = make_packet(OP_SND_REQ, 16'h0000);
        end
    end

    // Pending flags: a new request wins over a same-cycle clear, so a request
    // landing on the acceptance cycle is served by the next packet.
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            po_pend  <= 1'b0;
            snd_pend <= 1'b0;
        end else begin
            po_pend  <= power_on_req || (po_pend && !(accept && owner == SRC_PO));
            snd_pend <= snd_req_mode &&
                        (snd_req_tick || (snd_pend && !(accept && owner == SRC_SND)));
        end
    end

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            kb_overflow <= 1'b0;
        end else begin
            kb_overflow <= kb_drop;
        end
    end

    always_ff @(posedge mon_clk) begin
        if (reset) begin
            state     <= IDLE;
            owner     <= SRC_PO;
            gap_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_pend) begin
                        out_data  <= win_pkt;
                        out_valid <= 1'b1;
                        owner     <= win_src;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        gap_cnt   <= GAP_LOAD;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MON_TX_DROP_COUNT_EN
    always_ff @(posedge mon_clk) begin
        if (reset) begin
            drop_count <= 8'h00;
        end else if (kb_drop && drop_count != 8'hFF) begin
            drop_count <= drop_count + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_mon_tx_scheduler.sv
// tb_mon_tx_scheduler: directed, self-checking bench for mon_tx_scheduler
// (KB_DEPTH = 4, GAP_CYCLES = 16). A table of single-request scenarios checks
// reset state, packet formats, priority and two-cycle latency; hand-written
// sequences cover gap spacing, queue overflow, coalescing, mode cancel and
// reset during ISSUE. Build with MON_TX_DROP_COUNT_EN to add drop_count checks.
module tb_mon_tx_scheduler;

    localparam int KB_DEPTH   = 4;
    localparam int GAP_CYCLES = 16;

    logic        mon_clk;
    logic        reset;
    logic        power_on_req;
    logic        kb_valid;
    logic        kb_is_mouse;
    logic [15:0] kb_data;
    logic        snd_req_mode;
    logic        snd_req_tick;
    logic [39:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        kb_overflow;
`ifdef MON_TX_DROP_COUNT_EN
    logic [7:0]  drop_count;
`endif

    mon_tx_scheduler #(
        .KB_DEPTH   (KB_DEPTH),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .mon_clk      (mon_clk),
        .reset        (reset),
        .power_on_req (power_on_req),
        .kb_valid     (kb_valid),
        .kb_is_mouse  (kb_is_mouse),
        .kb_data      (kb_data),
        .snd_req_mode (snd_req_mode),
        .snd_req_tick (snd_req_tick),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .kb_overflow  (kb_overflow)
`ifdef MON_TX_DROP_COUNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    initial mon_clk = 1'b0;
    always #5 mon_clk = ~mon_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int ovf_cnt  = 0;
    logic [39:0] acc_data[$];
    int          acc_cyc[$];

    typedef struct {
        logic        po;
        logic        kbv;
        logic        mouse;
        logic [15:0] data;
        logic        mode;
        logic        tick;
        logic        exp_v;
        logic [39:0] exp_d;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Observe the current cycle (accepted packets, overflow pulses), then
    // advance to 1 time unit after the next rising edge.
    task automatic step();
        if (out_valid && out_ready) begin
            acc_data.push_back(out_data);
            acc_cyc.push_back(cycle);
        end
        if (kb_overflow) ovf_cnt++;
        @(posedge mon_clk);
        #1;
        cycle++;
    endtask

    task automatic clear_pulses();
        power_on_req = 1'b0;
        kb_valid     = 1'b0;
        snd_req_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_pulses();
        step();
        step();
        reset = 1'b0;
        acc_data.delete();
        acc_cyc.delete();
        ovf_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic stable_bad;

        reset        = 1'b1;
        out_ready    = 1'b1;
        snd_req_mode = 1'b0;
        kb_is_mouse  = 1'b0;
        kb_data      = 16'h0000;
        clear_pulses();
        #1;

        //            po    kbv   mouse data      mode  tick  exp_v exp_d
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 40'hC0_0000_0000};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 40'h07_0000_0000};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 40'hC5_1234_0000};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, 40'hC6_ABCD_0000};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 40'h00_0000_0000};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1, 40'hC5_FFFF_0000};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 40'hC0_0000_0000};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h5555, 1'b1, 1'b1, 1'b1, 40'h07_0000_0000};

        // Table: reset state, format, priority, two-cycle latency, one-cycle valid.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            check($sformatf("v%0d_rst_valid", i), 40'(out_valid), 40'h0);
            check($sformatf("v%0d_rst_data", i), out_data, 40'h0);
            check($sformatf("v%0d_rst_ovf", i), 40'(kb_overflow), 40'h0);
            out_ready    = 1'b1;
            power_on_req = vecs[i].po;
            kb_valid     = vecs[i].kbv;
            kb_is_mouse  = vecs[i].mouse;
            kb_data      = vecs[i].data;
            snd_req_mode = vecs[i].mode;
            snd_req_tick = vecs[i].tick;
            step();
            clear_pulses();
            check($sformatf("v%0d_n1_valid", i), 40'(out_valid), 40'h0);
            step();
            check($sformatf("v%0d_n2_valid", i), 40'(out_valid), 40'(vecs[i].exp_v));
            check($sformatf("v%0d_n2_data", i), out_data, vecs[i].exp_d);
            check($sformatf("v%0d_n2_ovf", i), 40'(kb_overflow), 40'h0);
            step();
            check($sformatf("v%0d_n3_valid", i), 40'(out_valid), 40'h0);
        end

        // Three simultaneous sources: order and exact gap spacing.
        do_reset();
        out_ready    = 1'b1;
        snd_req_mode = 1'b1;
        power_on_req = 1'b1;
        snd_req_tick = 1'b1;
        kb_valid     = 1'b1;
        kb_is_mouse  = 1'b0;
        kb_data      = 16'h1234;
        c0 = cycle;
        step();
        clear_pulses();
        repeat (70) step();
        check("three_count", 40'(acc_data.size()), 40'd3);
        if (acc_data.size() == 3) begin
            check("three_pkt0", acc_data[0], 40'hC0_0000_0000);
            check("three_pkt1", acc_data[1], 40'h07_0000_0000);
            check("three_pkt2", acc_data[2], 40'hC5_1234_0000);
            check("three_lat", 40'(acc_cyc[0] - c0), 40'd2);
            check("three_gap01", 40'(acc_cyc[1] - acc_cyc[0]), 40'(GAP_CYCLES + 2));
            check("three_gap12", 40'(acc_cyc[2] - acc_cyc[1]), 40'(GAP_CYCLES + 2));
        end

        // Queue overflow while the Sender stalls for 50 cycles.
        do_reset();
        snd_req_mode = 1'b0;
        out_ready    = 1'b0;
        kb_is_mouse  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            kb_valid = 1'b1;
            kb_data  = 16'h1000 + 16'(i);
            step();
        end
        clear_pulses();
        stable_bad = 1'b0;
        for (int i = 0; i < 44; i++) begin
            if (!out_valid || out_data !== 40'hC5_1000_0000) stable_bad = 1'b1;
            step();
        end
        check("stall_hold_stable", 40'(stable_bad), 40'h0);
        check("stall_ovf_pulses", 40'(ovf_cnt), 40'd1);
        out_ready = 1'b1;
        repeat (150) step();
        check("stall_count", 40'(acc_data.size()), 40'd5);
        if (acc_data.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("stall_pkt%0d", i), acc_data[i],
                      {8'hC5, 16'h1000 + 16'(i), 16'h0000});
            end
        end

        // Two ticks while pending coalesce into one packet.
        do_reset();
        out_ready    = 1'b1;
        snd_req_mode = 1'b1;
        snd_req_tick = 1'b1;
        step();
        snd_req_tick = 1'b1;
        step();
        clear_pulses();
        repeat (60) step();
        check("coalesce_count", 40'(acc_data.size()), 40'd1);
        if (acc_data.size() == 1) check("coalesce_pkt", acc_data[0], 40'h07_0000_0000);

        // Falling mode cancels a waiting sample request.
        do_reset();
        out_ready    = 1'b0;
        snd_req_mode = 1'b1;
        power_on_req = 1'b1;
        step();
        clear_pulses();
        snd_req_tick = 1'b1;
        step();
        clear_pulses();
        step();
        snd_req_mode = 1'b0;
        step();
        step();
        out_ready = 1'b1;
        repeat (60) step();
        check("modefall_count", 40'(acc_data.size()), 40'd1);
        if (acc_data.size() == 1) check("modefall_pkt", acc_data[0], 40'hC0_0000_0000);

        // Reset during ISSUE: packet abandoned, queue emptied, coincident requests ignored.
        do_reset();
        out_ready    = 1'b0;
        kb_is_mouse  = 1'b0;
        kb_valid     = 1'b1;
        kb_data      = 16'hAAAA;
        step();
        kb_data      = 16'hBBBB;
        step();
        clear_pulses();
        step();
        check("rstissue_pre_valid", 40'(out_valid), 40'h1);
        reset        = 1'b1;
        kb_valid     = 1'b1;
        kb_data      = 16'hCCCC;
        power_on_req = 1'b1;
        step();
        reset = 1'b0;
        clear_pulses();
        check("rstissue_valid", 40'(out_valid), 40'h0);
        check("rstissue_data", out_data, 40'h0);
        out_ready = 1'b1;
        repeat (60) step();
        check("rstissue_no_stale", 40'(acc_data.size()), 40'd0);

`ifdef MON_TX_DROP_COUNT_EN
        // Saturating drop counter.
        do_reset();
        check("drop_rst", 40'(drop_count), 40'h0);
        out_ready   = 1'b0;
        kb_valid    = 1'b1;
        kb_data     = 16'h7777;
        repeat (320) step();
        clear_pulses();
        step();
        check("drop_sat", 40'(drop_count), 40'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
